// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract engine sequencing one full-adder slice over WIDTH cycles
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = p ? ci : a;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] a_sr, b_sr, r_nxt;
  logic [WIDTH-2:0] r_sr;
  logic [CNT_W-1:0] cnt;
  logic carry, s, c_next, last;
  full_adder u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(carry), .s(s), .co(c_next));
  assign r_nxt = {s, r_sr};
  assign last  = cnt == CNT_W'(WIDTH - 1);
  assign busy  = state == RUN;
  assign done  = state == DONE;
  always_comb begin
    nxt = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        a_sr  <= op_a;
        b_sr  <= sub ? ~op_b : op_b;
        carry <= sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        r_sr  <= r_nxt[WIDTH-1:1];
        carry <= c_next;
        cnt   <= cnt + CNT_W'(1);
        // carry register still holds the carry into the MSB on the final step
        if (last) begin
          sum  <= r_nxt;
          cout <= c_next;
          ovf  <= carry ^ c_next;
        end
      end
    end
  end
endmodule
